// File: rtl/utils_pkg.sv
// Shared AXI types and helpers for the boot-ROM read-burst adapter.
// Also holds the FSM encodings used by the adapter.
package utils_pkg;

  typedef enum logic [1:0] {
    AXI_FIXED = 2'd0,
    AXI_INCR  = 2'd1,
    AXI_WRAP  = 2'd2,
    AXI_RSVD  = 2'd3
  } axi_burst_t;

  typedef logic [1:0] axi_error_t;
  localparam axi_error_t AXI_OKAY   = 2'b00;
  localparam axi_error_t AXI_SLVERR = 2'b10;

  typedef struct packed {
    logic        arvalid;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rready;
    logic        awvalid;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        wvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        bready;
  } s_axi_mosi_t;

  typedef struct packed {
    logic        arready;
    logic        rvalid;
    logic [3:0]  rid;
    logic [31:0] rdata;
    axi_error_t  rresp;
    logic        rlast;
    logic        awready;
    logic        wready;
    logic        bvalid;
    logic [3:0]  bid;
    axi_error_t  bresp;
  } s_axi_miso_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    axi_error_t  resp;
    logic        last;
  } r_beat_t;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_ADDR = 2'd1,
    RD_DATA = 2'd2
  } rd_state_t;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_DATA = 2'd1,
    WR_RESP = 2'd2
  } wr_state_t;

  // Byte-offset mask of a WRAP window: ((len+1) << size) - 1.
  function automatic logic [31:0] wrap_mask(input logic [7:0] len, input logic [2:0] size);
    logic [31:0] win_s;
    win_s = ({24'd0, len} + 32'd1) << size;
    return win_s - 32'd1;
  endfunction

endpackage

// File: rtl/axi_rom_burst_adapter_if.sv
// AXI request/response bundle; master drives mosi, slave drives miso.
interface axi_rom_burst_adapter_if;
  import utils_pkg::*;

  s_axi_mosi_t mosi;
  s_axi_miso_t miso;

  modport master (output mosi, input miso);
  modport slave  (input mosi, output miso);

endinterface

// File: rtl/axi_rom_burst_adapter_rd_resp_buf.sv
// One-entry R-channel holding register: loads only when empty,
// empties on an upstream handshake.
module axi_rd_resp_buf
  import utils_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    load,
  input  r_beat_t load_beat,
  input  logic    out_ready,
  output logic    out_valid,
  output r_beat_t out_beat
);

  logic    valid_r;
  r_beat_t beat_r;

  // Slot occupancy and captured beat
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= 1'b0;
      beat_r  <= '0;
    end else if (load && !valid_r) begin
      valid_r <= 1'b1;
      beat_r  <= load_beat;
    end else if (valid_r && out_ready) begin
      valid_r <= 1'b0;
    end
  end

  assign out_valid = valid_r;
  assign out_beat  = beat_r;

endmodule

// File: rtl/axi_rom_burst_adapter.sv
// Splits upstream AXI read bursts into single-beat ROM reads and
// terminates every write locally with SLVERR.
module axi_rom_burst_adapter
  import utils_pkg::*;
#(
  parameter int unsigned MAX_SIZE = 2
) (
  input logic                     clk,
  input logic                     rst,
  axi_rom_burst_adapter_if.slave  s,
  axi_rom_burst_adapter_if.master m
);

  rd_state_t   rd_state_r, rd_state_nxt_s;
  wr_state_t   wr_state_r, wr_state_nxt_s;
  logic [3:0]  rd_id_r, wr_id_r;
  logic [31:0] cur_addr_r;
  logic [7:0]  rd_len_r, beat_r;
  logic [2:0]  rd_size_r;
  axi_burst_t  rd_burst_r;
  logic        rd_err_r;

  logic        illegal_s, last_beat_s, load_s;
  logic [31:0] incr_s, mask_s, next_addr_s;
  logic        buf_valid_s;
  r_beat_t     buf_beat_s, load_beat_s;
  s_axi_mosi_t m_mosi_s;
  s_axi_miso_t s_miso_s;
  logic        wr_awready_s, wr_wready_s, wr_bvalid_s;
  logic        unused_s;

  assign illegal_s = ({29'd0, s.mosi.arsize} > MAX_SIZE) || (s.mosi.arburst == AXI_RSVD);

  // Read FSM state register
  always_ff @(posedge clk) begin
    if (rst) rd_state_r <= RD_IDLE;
    else     rd_state_r <= rd_state_nxt_s;
  end

  // Latched burst context, beat counter and running address
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_id_r    <= 4'd0;
      cur_addr_r <= 32'd0;
      rd_len_r   <= 8'd0;
      rd_size_r  <= 3'd0;
      rd_burst_r <= AXI_FIXED;
      beat_r     <= 8'd0;
      rd_err_r   <= 1'b0;
    end else if (rd_state_r == RD_IDLE && s.mosi.arvalid) begin
      rd_id_r    <= s.mosi.arid;
      cur_addr_r <= s.mosi.araddr;
      rd_len_r   <= s.mosi.arlen;
      rd_size_r  <= s.mosi.arsize;
      rd_burst_r <= axi_burst_t'(s.mosi.arburst);
      beat_r     <= 8'd0;
      rd_err_r   <= illegal_s;
    end else if (load_s) begin
      beat_r     <= beat_r + 8'd1;
      cur_addr_r <= next_addr_s;
    end
  end

  // Beat capture into the output buffer and next-address arithmetic
  always_comb begin
    last_beat_s = (beat_r == rd_len_r);
    if (rd_state_r == RD_DATA && !buf_valid_s) begin
      load_s = rd_err_r ? 1'b1 : m.miso.rvalid;
    end else begin
      load_s = 1'b0;
    end
    load_beat_s.id   = rd_id_r;
    load_beat_s.data = rd_err_r ? 32'd0 : m.miso.rdata;
    load_beat_s.resp = rd_err_r ? AXI_SLVERR : m.miso.rresp;
    load_beat_s.last = last_beat_s;
    incr_s = 32'd1 << rd_size_r;
    mask_s = wrap_mask(rd_len_r, rd_size_r);
    case (rd_burst_r)
      AXI_FIXED: next_addr_s = cur_addr_r;
      AXI_INCR:  next_addr_s = cur_addr_r + incr_s;
      AXI_WRAP:  next_addr_s = (cur_addr_r & ~mask_s) | ((cur_addr_r + incr_s) & mask_s);
      default:   next_addr_s = cur_addr_r;
    endcase
  end

  // Read FSM next-state; illegal bursts bypass the downstream address phase
  always_comb begin
    rd_state_nxt_s = rd_state_r;
    case (rd_state_r)
      RD_IDLE: begin
        if (s.mosi.arvalid) rd_state_nxt_s = illegal_s ? RD_DATA : RD_ADDR;
        else                rd_state_nxt_s = RD_IDLE;
      end
      RD_ADDR: begin
        if (m.miso.arready) rd_state_nxt_s = RD_DATA;
        else                rd_state_nxt_s = RD_ADDR;
      end
      RD_DATA: begin
        if (load_s && last_beat_s)    rd_state_nxt_s = RD_IDLE;
        else if (load_s && !rd_err_r) rd_state_nxt_s = RD_ADDR;
        else                          rd_state_nxt_s = RD_DATA;
      end
      default: rd_state_nxt_s = RD_IDLE;
    endcase
  end

  // Downstream request from read state only; AW/W/B stay zero
  always_comb begin
    m_mosi_s         = '0;
    m_mosi_s.arvalid = (rd_state_r == RD_ADDR);
    m_mosi_s.arid    = rd_id_r;
    m_mosi_s.araddr  = cur_addr_r;
    m_mosi_s.arlen   = 8'd0;
    m_mosi_s.arsize  = rd_size_r;
    m_mosi_s.arburst = AXI_INCR;
    case (rd_state_r)
      RD_IDLE: m_mosi_s.rready = 1'b1;
      RD_ADDR: m_mosi_s.rready = 1'b0;
      RD_DATA: m_mosi_s.rready = ~buf_valid_s;
      default: m_mosi_s.rready = 1'b1;
    endcase
  end

  assign m.mosi = m_mosi_s;

  axi_rd_resp_buf u_rd_resp_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (load_s),
    .load_beat (load_beat_s),
    .out_ready (s.mosi.rready),
    .out_valid (buf_valid_s),
    .out_beat  (buf_beat_s)
  );

  // Write FSM state register and captured AWID
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_r <= WR_IDLE;
      wr_id_r    <= 4'd0;
    end else begin
      wr_state_r <= wr_state_nxt_s;
      if (wr_state_r == WR_IDLE && s.mosi.awvalid) wr_id_r <= s.mosi.awid;
    end
  end

  // Write FSM next-state
  always_comb begin
    wr_state_nxt_s = wr_state_r;
    case (wr_state_r)
      WR_IDLE: wr_state_nxt_s = s.mosi.awvalid ? WR_DATA : WR_IDLE;
      WR_DATA: wr_state_nxt_s = (s.mosi.wvalid && s.mosi.wlast) ? WR_RESP : WR_DATA;
      WR_RESP: wr_state_nxt_s = s.mosi.bready ? WR_IDLE : WR_RESP;
      default: wr_state_nxt_s = WR_IDLE;
    endcase
  end

  // Write FSM outputs
  always_comb begin
    wr_awready_s = 1'b0;
    wr_wready_s  = 1'b0;
    wr_bvalid_s  = 1'b0;
    case (wr_state_r)
      WR_IDLE: wr_awready_s = 1'b1;
      WR_DATA: wr_wready_s  = 1'b1;
      WR_RESP: wr_bvalid_s  = 1'b1;
      default: wr_awready_s = 1'b0;
    endcase
  end

  // Upstream response assembly
  always_comb begin
    s_miso_s         = '0;
    s_miso_s.arready = (rd_state_r == RD_IDLE);
    s_miso_s.rvalid  = buf_valid_s;
    s_miso_s.rid     = buf_beat_s.id;
    s_miso_s.rdata   = buf_beat_s.data;
    s_miso_s.rresp   = buf_beat_s.resp;
    s_miso_s.rlast   = buf_beat_s.last;
    s_miso_s.awready = wr_awready_s;
    s_miso_s.wready  = wr_wready_s;
    s_miso_s.bvalid  = wr_bvalid_s;
    s_miso_s.bid     = wr_id_r;
    s_miso_s.bresp   = AXI_SLVERR;
  end

  assign s.miso = s_miso_s;

  assign unused_s = ^{s.mosi.awaddr, s.mosi.awlen, s.mosi.awsize, s.mosi.awburst,
                      s.mosi.wdata, s.mosi.wstrb, m.miso.rid, m.miso.rlast,
                      m.miso.awready, m.miso.wready, m.miso.bvalid, m.miso.bid,
                      m.miso.bresp};

endmodule

// File: tb/tb_axi_rom_burst_adapter.sv
// Directed bench for axi_rom_burst_adapter: a ROM responder, a burst-level
// expectation model and a per-cycle compare process.
module tb_axi_rom_burst_adapter;
  import utils_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_rom_burst_adapter_if s_if ();
  axi_rom_burst_adapter_if m_if ();

  axi_rom_burst_adapter #(.MAX_SIZE(2)) dut (
    .clk (clk),
    .rst (rst),
    .s   (s_if.slave),
    .m   (m_if.master)
  );

  logic        ar_valid = 1'b0;
  logic [3:0]  ar_id    = 4'd0;
  logic [31:0] ar_addr  = 32'd0;
  logic [7:0]  ar_len   = 8'd0;
  logic [2:0]  ar_size  = 3'd0;
  logic [1:0]  ar_burst = 2'd0;
  logic        r_ready  = 1'b1;
  logic        aw_valid = 1'b0;
  logic [3:0]  aw_id    = 4'd0;
  logic        w_valid  = 1'b0;
  logic        w_last   = 1'b0;
  logic        b_ready  = 1'b1;
  logic        rom_rvalid = 1'b0;
  logic [31:0] rom_rdata  = 32'd0;
  logic        bp_mode  = 1'b0;
  int          bp_cnt   = 0;

  always_comb begin
    s_if.mosi         = '0;
    s_if.mosi.arvalid = ar_valid;
    s_if.mosi.arid    = ar_id;
    s_if.mosi.araddr  = ar_addr;
    s_if.mosi.arlen   = ar_len;
    s_if.mosi.arsize  = ar_size;
    s_if.mosi.arburst = ar_burst;
    s_if.mosi.rready  = r_ready;
    s_if.mosi.awvalid = aw_valid;
    s_if.mosi.awid    = aw_id;
    s_if.mosi.wvalid  = w_valid;
    s_if.mosi.wlast   = w_last;
    s_if.mosi.bready  = b_ready;
  end

  always_comb begin
    m_if.miso         = '0;
    m_if.miso.arready = 1'b1;
    m_if.miso.rvalid  = rom_rvalid;
    m_if.miso.rdata   = rom_rdata;
    m_if.miso.rresp   = AXI_OKAY;
  end

  r_beat_t     exp_r[$];
  logic [31:0] exp_a[$];
  logic [3:0]  exp_b[$];
  logic [31:0] act_a[$];
  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {a[31:16] ^ 16'hC0DE, a[15:0] ^ 16'h0F0F};
  endfunction

  // Address of beat i, straight from the burst definitions.
  function automatic logic [31:0] beat_addr(input logic [31:0] a, input int len,
                                            input int size, input int burst, input int i);
    longint unsigned ua, incr, win, base;
    ua   = {32'd0, a};
    incr = 64'd1 << size;
    win  = 64'(len + 1) * incr;
    case (burst)
      1: ua = ua + 64'(i) * incr;
      2: begin
        base = ua - (ua % win);
        ua   = base + ((ua - base + 64'(i) * incr) % win);
      end
      default: ua = ua;
    endcase
    return ua[31:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: actual=timeout required=completion", name);
  endtask

  task automatic push_read(input logic [3:0] id, input logic [31:0] a, input int len,
                           input int size, input int burst);
    r_beat_t b;
    logic [31:0] ba;
    for (int i = 0; i <= len; i++) begin
      ba     = beat_addr(a, len, size, burst, i);
      b.id   = id;
      b.last = (i == len);
      if (size <= 2 && burst != 3) begin
        exp_a.push_back(ba);
        b.data = rom_word(ba);
        b.resp = AXI_OKAY;
      end else begin
        b.data = 32'd0;
        b.resp = AXI_SLVERR;
      end
      exp_r.push_back(b);
    end
  endtask

  task automatic ar_send(input logic [3:0] id, input logic [31:0] a, input int len,
                         input int size, input int burst);
    bit ok = 1'b0;
    push_read(id, a, len, size, burst);
    @(posedge clk); #1;
    ar_valid = 1'b1; ar_id = id; ar_addr = a;
    ar_len = 8'(len); ar_size = 3'(size); ar_burst = 2'(burst);
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (s_if.miso.arready) begin ok = 1'b1; break; end
    end
    if (!ok) timeout_fail("ar_accept");
    @(posedge clk); #1;
    ar_valid = 1'b0;
  endtask

  task automatic wr_send(input logic [3:0] id, input int nbeats);
    bit ok = 1'b0;
    exp_b.push_back(id);
    @(posedge clk); #1;
    aw_valid = 1'b1; aw_id = id;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (s_if.miso.awready) begin ok = 1'b1; break; end
    end
    if (!ok) timeout_fail("aw_accept");
    @(posedge clk); #1;
    aw_valid = 1'b0;
    for (int j = 0; j < nbeats; j++) begin
      w_valid = 1'b1; w_last = (j == nbeats - 1);
      ok = 1'b0;
      for (int k = 0; k < 300; k++) begin
        @(negedge clk);
        if (s_if.miso.wready) begin ok = 1'b1; break; end
      end
      if (!ok) timeout_fail("w_accept");
      @(posedge clk); #1;
    end
    w_valid = 1'b0; w_last = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (exp_r.size() == 0 && exp_a.size() == 0 && exp_b.size() == 0 &&
          !s_if.miso.rvalid && !s_if.miso.bvalid) begin ok = 1'b1; break; end
    end
    if (!ok) timeout_fail("burst_complete");
  endtask

  // ROM slave: single-beat reads, data one cycle after AR, held until taken
  initial begin
    logic arf, rf, rs;
    logic [31:0] aa;
    forever begin
      @(negedge clk);
      arf = m_if.mosi.arvalid && m_if.miso.arready;
      rf  = m_if.miso.rvalid && m_if.mosi.rready;
      aa  = m_if.mosi.araddr;
      rs  = rst;
      @(posedge clk); #1;
      if (rs) rom_rvalid = 1'b0;
      else begin
        if (rf) rom_rvalid = 1'b0;
        if (arf) begin rom_rvalid = 1'b1; rom_rdata = rom_word(aa); end
      end
    end
  end

  // Upstream R-ready: constant 1, or toggling every two cycles
  initial begin
    forever begin
      @(posedge clk); #1;
      if (bp_mode) begin
        bp_cnt  = bp_cnt + 1;
        r_ready = bp_cnt[1];
      end else begin
        r_ready = 1'b1;
      end
    end
  end

  // Per-cycle comparison against the model queues
  initial begin
    r_beat_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (m_if.mosi.arvalid && m_if.miso.arready) begin
          act_a.push_back(m_if.mosi.araddr);
          if (exp_a.size() == 0) timeout_fail("m_ar_unexpected");
          else check("m_araddr", m_if.mosi.araddr, exp_a.pop_front());
          check("m_arlen", {24'd0, m_if.mosi.arlen}, 32'd0);
        end
        if (s_if.miso.rvalid && s_if.mosi.rready) begin
          if (exp_r.size() == 0) timeout_fail("s_r_unexpected");
          else begin
            e = exp_r.pop_front();
            check("s_rdata", s_if.miso.rdata, e.data);
            check("s_rresp", {30'd0, s_if.miso.rresp}, {30'd0, e.resp});
            check("s_rid", {28'd0, s_if.miso.rid}, {28'd0, e.id});
            check1("s_rlast", s_if.miso.rlast, e.last);
          end
        end
        if (s_if.miso.rvalid && !s_if.miso.rlast)
          check1("m_rready_while_full", m_if.mosi.rready, 1'b0);
        if (s_if.miso.bvalid && s_if.mosi.bready) begin
          if (exp_b.size() == 0) timeout_fail("s_b_unexpected");
          else check("s_bid", {28'd0, s_if.miso.bid}, {28'd0, exp_b.pop_front()});
          check("s_bresp", {30'd0, s_if.miso.bresp}, {30'd0, AXI_SLVERR});
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check1("rst_arready", s_if.miso.arready, 1'b1);
    check1("rst_awready", s_if.miso.awready, 1'b1);
    check1("rst_rvalid", s_if.miso.rvalid, 1'b0);
    check1("rst_bvalid", s_if.miso.bvalid, 1'b0);
    check1("rst_m_arvalid", m_if.mosi.arvalid, 1'b0);
    check1("rst_m_rready", m_if.mosi.rready, 1'b1);

    check("model_wrap_beat2", beat_addr(32'h18, 3, 2, 2, 2), 32'h10);
    check("model_incr_beat3", beat_addr(32'h100, 3, 2, 1, 3), 32'h10C);
    check("model_incr_mod32", beat_addr(32'hFFFF_FFFC, 1, 2, 1, 1), 32'h0);

    // INCR burst with first-beat latency
    act_a.delete();
    ar_send(4'h3, 32'h100, 3, 2, 1);
    @(negedge clk);
    check1("lat_m_arvalid_t1", m_if.mosi.arvalid, 1'b1);
    check1("lat_s_rvalid_t1", s_if.miso.rvalid, 1'b0);
    @(negedge clk);
    check1("lat_m_rvalid_t2", m_if.miso.rvalid, 1'b1);
    @(negedge clk);
    check1("lat_s_rvalid_t3", s_if.miso.rvalid, 1'b1);
    wait_done(200);
    check("incr_ar_count", act_a.size(), 32'd4);
    if (act_a.size() == 4) begin
      check("incr_a0", act_a[0], 32'h100);
      check("incr_a3", act_a[3], 32'h10C);
    end

    // WRAP burst
    act_a.delete();
    ar_send(4'h6, 32'h18, 3, 2, 2);
    wait_done(200);
    check("wrap_ar_count", act_a.size(), 32'd4);
    if (act_a.size() == 4) begin
      check("wrap_a0", act_a[0], 32'h18);
      check("wrap_a1", act_a[1], 32'h1C);
      check("wrap_a2", act_a[2], 32'h10);
      check("wrap_a3", act_a[3], 32'h14);
    end

    // Upstream backpressure
    act_a.delete();
    bp_mode = 1'b1;
    ar_send(4'h9, 32'h200, 7, 2, 1);
    wait_done(400);
    bp_mode = 1'b0;
    check("bp_ar_count", act_a.size(), 32'd8);

    // Illegal size and reserved burst type
    act_a.delete();
    ar_send(4'hA, 32'h300, 1, 3, 1);
    wait_done(200);
    ar_send(4'hB, 32'h40, 0, 2, 3);
    wait_done(200);
    check("illegal_ar_count", act_a.size(), 32'd0);

    // Write terminated locally, concurrent read
    fork
      wr_send(4'h5, 3);
      ar_send(4'h2, 32'h400, 1, 1, 1);
    join
    wait_done(300);

    // Reset in the middle of beat 2
    ar_send(4'h7, 32'h500, 3, 2, 1);
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (exp_r.size() == 3) begin ok = 1'b1; break; end
    end
    if (!ok) timeout_fail("first_beat_before_reset");
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check1("mid_rst_rvalid", s_if.miso.rvalid, 1'b0);
    check1("mid_rst_bvalid", s_if.miso.bvalid, 1'b0);
    check1("mid_rst_m_arvalid", m_if.mosi.arvalid, 1'b0);
    check1("mid_rst_arready", s_if.miso.arready, 1'b1);
    check1("mid_rst_awready", s_if.miso.awready, 1'b1);
    exp_r.delete();
    exp_a.delete();
    ar_send(4'hC, 32'h600, 0, 2, 1);
    wait_done(200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
